// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
// MEM-stage responder: takes one load/store at a time, runs it on a req/ack
// data-memory bus, and returns an extended load result or an error pulse.
// Optional feature macro: DMAU_TIMEOUT_EN (abort REQ after TIMEOUT_CYCLES).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a request; bus idle
// REQ     | bus request held with stable mem_* outputs, waiting for ack
// RESP    | one-cycle response pulse (result, or error with zero data)

module data_mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        data_mem_we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              req_err;
    logic              tmo_hit;
    logic [31:0]       load_ext;

    assign accept = (state_q == ST_IDLE) && req_valid_i;

    // Legality and alignment of the request currently on the inputs
    always_comb begin
        req_err = 1'b0;
        case (data_mem_we_i)
            2'b00: begin
                case (funct3_i)
                    3'b000, 3'b100: req_err = 1'b0;
                    3'b001, 3'b101: req_err = addr_i[0];
                    3'b010:         req_err = |addr_i[1:0];
                    default:        req_err = 1'b1;
                endcase
            end
            2'b01:   req_err = 1'b0;
            2'b10:   req_err = addr_i[0];
            default: req_err = |addr_i[1:0];
        endcase
    end

`ifdef DMAU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q;

    // Down-counter loaded on REQ entry; zero marks the last allowed REQ cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else if (accept) begin
            tmo_cnt_q <= TMO_LOAD;
        end else if ((state_q == ST_REQ) && (tmo_cnt_q != '0)) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end

    assign tmo_hit = (state_q == ST_REQ) && (tmo_cnt_q == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    // Lane selection and sign/zero extension of the returned word
    always_comb begin
        logic [7:0]  rd_byte;
        logic [15:0] rd_half;
        case (addr_q[1:0])
            2'b00:   rd_byte = mem_rdata_i[7:0];
            2'b01:   rd_byte = mem_rdata_i[15:8];
            2'b10:   rd_byte = mem_rdata_i[23:16];
            default: rd_byte = mem_rdata_i[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_ext = mem_rdata_i;
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack takes priority over a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d = req_err ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack_i || tmo_hit) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture on accept, result capture on ack or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 2'b00;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else if (accept) begin
            we_q     <= data_mem_we_i;
            funct3_q <= funct3_i;
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            err_q    <= req_err;
            rdata_q  <= 32'd0;
        end else if (state_q == ST_REQ) begin
            if (mem_ack_i) begin
                rdata_q <= (we_q == 2'b00) ? load_ext : 32'd0;
            end else if (tmo_hit) begin
                err_q   <= 1'b1;
                rdata_q <= 32'd0;
            end
        end
    end

    // Bus and response outputs; everything on the bus is zero outside REQ
    always_comb begin
        logic       in_req;
        logic [3:0] be;
        logic [31:0] wd;
        in_req = (state_q == ST_REQ);
        case (we_q)
            2'b00: begin
                be = 4'b1111;
                wd = 32'd0;
            end
            2'b01: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'b10: begin
                be = 4'b0011 << {addr_q[1], 1'b0};
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
        req_ready_o = (state_q == ST_IDLE);
        mem_req_o   = in_req;
        mem_we_o    = in_req && (we_q != 2'b00);
        mem_be_o    = in_req ? be : 4'b0000;
        mem_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata_o = in_req ? wd : 32'd0;
        rsp_valid_o = (state_q == ST_RESP);
        rsp_rdata_o = (state_q == ST_RESP) ? rdata_q : 32'd0;
        err_o       = (state_q == ST_RESP) && err_q;
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: stimulus pushes expected bus
// transactions and responses; a bus responder and a response monitor check them.

module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  data_mem_we_i = 2'b00;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        err_o;

    logic ack_drv = 1'b0;
    logic stray_ack = 1'b0;
    assign mem_ack_i = ack_drv | stray_ack;

    data_mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .data_mem_we_i(data_mem_we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          exp_cyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;       // wait cycles before ack; -1 = never ack
        logic [31:0] rdata;
        int          req_cycles;  // >0: expected mem_req high cycles without ack
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];

    int compared = 0;
    int mismatched = 0;
    bit busy = 1'b0;
    bit ready_due = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request (caller is at a negedge); returns at the negedge after accept
    task automatic issue(input logic [1:0] we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hold, input bit has_bus,
                         input logic [3:0] be, input logic [31:0] maddr,
                         input logic [31:0] mwdata, input int delay,
                         input logic [31:0] rdata, input int req_cycles,
                         input bit has_rsp, input logic [31:0] exp_rdata,
                         input logic exp_err, input int off);
        int n;
        bus_t b;
        rsp_t r;
        data_mem_we_i = we;
        funct3_i      = f3;
        addr_i        = addr;
        wdata_i       = wdata;
        req_valid_i   = 1'b1;
        n = 0;
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: req_ready stayed 0 for addr 0x%08h", addr);
            req_valid_i = 1'b0;
            return;
        end
        if (has_bus) begin
            b.we = (we != 2'b00); b.be = be; b.addr = maddr; b.wdata = mwdata;
            b.delay = delay; b.rdata = rdata; b.req_cycles = req_cycles;
            bus_q.push_back(b);
        end
        if (has_rsp) begin
            r.rdata = exp_rdata; r.err = exp_err; r.exp_cyc = cyc + off;
            rsp_q.push_back(r);
        end
        @(posedge clk);
        busy = 1'b1;
        @(negedge clk);
        req_valid_i = hold;
    endtask

    // Bus responder: checks each mem_req against the expected transaction and acks it
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                if (bus_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_mem_req: addr 0x%08h at cycle %0d", mem_addr_o, cyc);
                end else begin
                    bus_t b;
                    int n;
                    b = bus_q.pop_front();
                    n = 0;
                    forever begin
                        n++;
                        chk("mem_we", {31'd0, mem_we_o}, {31'd0, b.we});
                        chk("mem_be", {28'd0, mem_be_o}, {28'd0, b.be});
                        chk("mem_addr", mem_addr_o, b.addr);
                        chk("mem_wdata", mem_wdata_o, b.wdata);
                        if (b.delay >= 0 && n - 1 == b.delay) begin
                            ack_drv = 1'b1;
                            mem_rdata_i = b.rdata;
                            @(negedge clk);
                            ack_drv = 1'b0;
                            mem_rdata_i = 32'd0;
                            break;
                        end
                        @(negedge clk);
                        if (!mem_req_o) begin
                            if (b.req_cycles > 0) chk("mem_req_cycles", n, b.req_cycles);
                            break;
                        end
                        if (n > 300) begin
                            compared++;
                            mismatched++;
                            $display("FAIL mem_req_stuck: still high after %0d cycles", n);
                            break;
                        end
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid and checks handshake
    initial begin
        forever begin
            @(negedge clk);
            if (busy) begin
                compared++;
                if (req_ready_o) begin
                    mismatched++;
                    $display("FAIL ready_while_busy: req_ready 1 expected 0 at cycle %0d", cyc);
                end
            end
            if (ready_due) begin
                chk("ready_after_rsp", {31'd0, req_ready_o}, 32'd1);
                ready_due = 1'b0;
            end
            if (!mem_req_o) begin
                chk("bus_idle_zero", {mem_we_o, mem_be_o, 27'd0} | mem_addr_o | mem_wdata_o, 32'd0);
            end
            if (rsp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_rsp: rdata 0x%08h err %0b at cycle %0d", rsp_rdata_o, err_o, cyc);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata_o, r.rdata);
                    chk("rsp_err", {31'd0, err_o}, {31'd0, r.err});
                    chk("rsp_cycle", cyc, r.exp_cyc);
                end
                busy = 1'b0;
                ready_due = 1'b1;
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", {31'd0, req_ready_o}, 32'd1);
        chk("reset_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("reset_err", {31'd0, err_o}, 32'd0);
        @(negedge clk);

        // SB at byte 3, ack on first REQ cycle
        issue(2'b01, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 1, 4'b1000, 32'h0000_1000,
              32'hDDDD_DDDD, 0, 32'h0, 0, 1, 32'h0, 1'b0, 2);
        // LH upper half, negative, 3 wait cycles
        issue(2'b00, 3'b001, 32'h0000_2002, 32'h0, 0, 1, 4'b1111, 32'h0000_2000,
              32'h0, 3, 32'h8001_1234, 0, 1, 32'hFFFF_8001, 1'b0, 5);
        // LHU same address and data
        issue(2'b00, 3'b101, 32'h0000_2002, 32'h0, 0, 1, 4'b1111, 32'h0000_2000,
              32'h0, 3, 32'h8001_1234, 0, 1, 32'h0000_8001, 1'b0, 5);
        // SW misaligned: error, no bus access
        issue(2'b11, 3'b000, 32'h0000_0006, 32'h1234_5678, 0, 0, 4'b0, 32'h0,
              32'h0, 0, 32'h0, 0, 1, 32'h0, 1'b1, 1);
        // Load with illegal funct3 at aligned address
        issue(2'b00, 3'b110, 32'h0000_0010, 32'h0, 0, 0, 4'b0, 32'h0,
              32'h0, 0, 32'h0, 0, 1, 32'h0, 1'b1, 1);
        // LH misaligned
        issue(2'b00, 3'b001, 32'h0000_2001, 32'h0, 0, 0, 4'b0, 32'h0,
              32'h0, 0, 32'h0, 0, 1, 32'h0, 1'b1, 1);
        // SH misaligned
        issue(2'b10, 3'b000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 4'b0, 32'h0,
              32'h0, 0, 32'h0, 0, 1, 32'h0, 1'b1, 1);
        // LB byte 1, sign bit set
        issue(2'b00, 3'b000, 32'h0000_3001, 32'h0, 0, 1, 4'b1111, 32'h0000_3000,
              32'h0, 1, 32'h1234_80FF, 0, 1, 32'hFFFF_FF80, 1'b0, 3);
        // LBU byte 3
        issue(2'b00, 3'b100, 32'h0000_3003, 32'h0, 0, 1, 4'b1111, 32'h0000_3000,
              32'h0, 0, 32'h7F00_0000, 0, 1, 32'h0000_007F, 1'b0, 2);
        // SH upper half
        issue(2'b10, 3'b000, 32'h0000_4002, 32'h1111_BEEF, 0, 1, 4'b1100, 32'h0000_4000,
              32'hBEEF_BEEF, 2, 32'h0, 0, 1, 32'h0, 1'b0, 4);
        // LW
        issue(2'b00, 3'b010, 32'h0000_5004, 32'h0, 0, 1, 4'b1111, 32'h0000_5004,
              32'h0, 0, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 1'b0, 2);
        // SB byte 2
        issue(2'b01, 3'b000, 32'h0000_0002, 32'h0000_005A, 0, 1, 4'b0100, 32'h0000_0000,
              32'h5A5A_5A5A, 0, 32'h0, 0, 1, 32'h0, 1'b0, 2);

        // Back-to-back with req_valid held: LB then SH
        issue(2'b00, 3'b000, 32'h0000_6000, 32'h0, 1, 1, 4'b1111, 32'h0000_6000,
              32'h0, 1, 32'h0000_00F0, 0, 1, 32'hFFFF_FFF0, 1'b0, 3);
        issue(2'b10, 3'b000, 32'h0000_6006, 32'h0000_CAFE, 0, 1, 4'b1100, 32'h0000_6004,
              32'hCAFE_CAFE, 0, 32'h0, 0, 1, 32'h0, 1'b0, 2);
        repeat (4) @(negedge clk);
        // Stray ack while idle must produce nothing
        stray_ack = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        stray_ack = 1'b0;
        mem_rdata_i = 32'd0;
        chk("stray_ack_ready", {31'd0, req_ready_o}, 32'd1);
        repeat (3) @(negedge clk);

        // Reset while in REQ: transaction is abandoned
        issue(2'b00, 3'b010, 32'h0000_7000, 32'h0, 0, 1, 4'b1111, 32'h0000_7000,
              32'h0, -1, 32'h0, 0, 0, 32'h0, 1'b0, 0);
        @(negedge clk);
        busy = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_req_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_req_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        @(negedge clk);
        chk("rst_req_rsp_valid_2", {31'd0, rsp_valid_o}, 32'd0);
        // Following request completes normally
        issue(2'b11, 3'b000, 32'h0000_7000, 32'h1234_5678, 0, 1, 4'b1111, 32'h0000_7000,
              32'h1234_5678, 1, 32'h0, 0, 1, 32'h0, 1'b0, 3);

`ifdef DMAU_TIMEOUT_EN
        // No ack: request held for 4 cycles, then error response
        issue(2'b00, 3'b010, 32'h0000_8000, 32'h0, 0, 1, 4'b1111, 32'h0000_8000,
              32'h0, -1, 32'h0, 4, 1, 32'h0, 1'b1, 5);
`endif

        n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || bus_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d responses and %0d bus transactions outstanding",
                     rsp_q.size(), bus_q.size());
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
